// File: rtl/grid_game_ctrl.sv
// grid_game_ctrl: N x N two-player grid game controller. Accepts one move at a time,
// then runs a 4-cycle line check. Optional per-turn forfeit timer: GRID_TURN_TIMEOUT_EN.
module grid_game_ctrl #(
    parameter int BOARD_N = 3,
    parameter int CW      = (BOARD_N > 1) ? $clog2(BOARD_N) : 1,
    parameter int TIMEOUT = 1000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           move_valid,
    input  logic [CW-1:0]                  sel_x,
    input  logic [CW-1:0]                  sel_y,
    output logic                           move_ack,
    output logic                           move_rej,
    output logic [BOARD_N*BOARD_N-1:0]     game_mem,
    output logic [BOARD_N*BOARD_N-1:0]     grid_active,
    output logic                           turn,
    output logic                           busy,
    output logic                           game_over,
    output logic                           winner_valid,
    output logic                           winner,
    output logic                           draw
`ifdef GRID_TURN_TIMEOUT_EN
    ,
    output logic                           timeout_pulse
`endif
);

    localparam int CELLS = BOARD_N * BOARD_N;

    // Line masks anchored at row 0 / column 0; rows and columns are shifted into place.
    function automatic logic [CELLS-1:0] mk_mask(input int kind);
        logic [CELLS-1:0] m;
        m = '0;
        for (int k = 0; k < BOARD_N; k++) begin
            case (kind)
                0:       m = m | (CELLS'(1) << k);
                1:       m = m | (CELLS'(1) << (k * BOARD_N));
                2:       m = m | (CELLS'(1) << (k * BOARD_N + k));
                default: m = m | (CELLS'(1) << (k * BOARD_N + BOARD_N - 1 - k));
            endcase
        end
        return m;
    endfunction

    localparam logic [CELLS-1:0] ROW0 = mk_mask(0);
    localparam logic [CELLS-1:0] COL0 = mk_mask(1);
    localparam logic [CELLS-1:0] DIAG = mk_mask(2);
    localparam logic [CELLS-1:0] ANTI = mk_mask(3);

    typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

    state_t           state_q;
    logic [CELLS-1:0] mem_q, act_q;
    logic             turn_q, ack_q, rej_q, busy_q, over_q, winv_q, win_q, draw_q;
    logic [1:0]       step_q;
    logic [CW-1:0]    cx_q, cy_q;
    logic             mover_q, hit_q;

    logic             in_range, occupied, accept, line_en, line_hit;
    logic [CELLS-1:0] sel_oh, line_mask, cell_ok;
    int               sel_idx;

    always_comb begin
        in_range = (int'(sel_x) < BOARD_N) && (int'(sel_y) < BOARD_N);
        sel_idx  = int'(sel_y) * BOARD_N + int'(sel_x);
        sel_oh   = in_range ? (CELLS'(1) << sel_idx) : '0;
        occupied = |(act_q & sel_oh);
        accept   = move_valid && in_range && !occupied;
    end

    // A cell counts toward a line only if it is occupied by the player who just moved.
    always_comb begin
        cell_ok   = act_q & ~(mem_q ^ {CELLS{mover_q}});
        line_mask = '0;
        line_en   = 1'b1;
        case (step_q)
            2'd0: line_mask = ROW0 << (int'(cy_q) * BOARD_N);
            2'd1: line_mask = COL0 << int'(cx_q);
            2'd2: begin
                line_mask = DIAG;
                line_en   = (cx_q == cy_q);
            end
            default: begin
                line_mask = ANTI;
                line_en   = ((int'(cx_q) + int'(cy_q)) == BOARD_N - 1);
            end
        endcase
        line_hit = line_en && ((cell_ok & line_mask) == line_mask);
    end

`ifdef GRID_TURN_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PLAY;
            mem_q   <= '0;
            act_q   <= '0;
            turn_q  <= 1'b0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            winv_q  <= 1'b0;
            win_q   <= 1'b0;
            draw_q  <= 1'b0;
            step_q  <= 2'd0;
            cx_q    <= '0;
            cy_q    <= '0;
            mover_q <= 1'b0;
            hit_q   <= 1'b0;
`ifdef GRID_TURN_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            rej_q <= 1'b0;
`ifdef GRID_TURN_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            if (clear) begin
                state_q <= S_PLAY;
                mem_q   <= '0;
                act_q   <= '0;
                turn_q  <= 1'b0;
                busy_q  <= 1'b0;
                over_q  <= 1'b0;
                winv_q  <= 1'b0;
                win_q   <= 1'b0;
                draw_q  <= 1'b0;
                step_q  <= 2'd0;
                cx_q    <= '0;
                cy_q    <= '0;
                mover_q <= 1'b0;
                hit_q   <= 1'b0;
`ifdef GRID_TURN_TIMEOUT_EN
                tmo_cnt_q <= '0;
`endif
            end else begin
                case (state_q)
                    S_PLAY: begin
                        if (accept) begin
                            act_q   <= act_q | sel_oh;
                            mem_q   <= turn_q ? (mem_q | sel_oh) : (mem_q & ~sel_oh);
                            ack_q   <= 1'b1;
                            cx_q    <= sel_x;
                            cy_q    <= sel_y;
                            mover_q <= turn_q;
                            step_q  <= 2'd0;
                            hit_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_CHECK;
                        end else if (move_valid) begin
                            rej_q <= 1'b1;
                        end
`ifdef GRID_TURN_TIMEOUT_EN
                        if (accept) begin
                            tmo_cnt_q <= '0;
                        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                            tmo_cnt_q <= '0;
                            turn_q    <= ~turn_q;
                            tmo_q     <= 1'b1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
`endif
                    end
                    S_CHECK: begin
                        if (step_q == 2'd3) begin
                            busy_q <= 1'b0;
                            step_q <= 2'd0;
                            if (hit_q || line_hit) begin
                                winv_q  <= 1'b1;
                                win_q   <= mover_q;
                                over_q  <= 1'b1;
                                state_q <= S_OVER;
                            end else if (&act_q) begin
                                draw_q  <= 1'b1;
                                over_q  <= 1'b1;
                                state_q <= S_OVER;
                            end else begin
                                turn_q  <= ~turn_q;
                                state_q <= S_PLAY;
                            end
                        end else begin
                            step_q <= step_q + 2'd1;
                            hit_q  <= hit_q | line_hit;
                        end
                    end
                    S_OVER: begin
                        if (move_valid) rej_q <= 1'b1;
                    end
                    default: state_q <= S_PLAY;
                endcase
            end
        end
    end

    assign move_ack     = ack_q;
    assign move_rej     = rej_q;
    assign game_mem     = mem_q;
    assign grid_active  = act_q;
    assign turn         = turn_q;
    assign busy         = busy_q;
    assign game_over    = over_q;
    assign winner_valid = winv_q;
    assign winner       = win_q;
    assign draw         = draw_q;
`ifdef GRID_TURN_TIMEOUT_EN
    assign timeout_pulse = tmo_q;
`endif

endmodule

// File: tb/tb_grid_game_ctrl.sv
// Scoreboard bench for grid_game_ctrl: a 3x3 and a 4x4 instance share clock, reset and clear.
module tb_grid_game_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    logic       mv3 = 1'b0, mv4 = 1'b0;
    logic [1:0] x3 = '0, y3 = '0, x4 = '0, y4 = '0;
    logic       ack3, rej3, turn3, busy3, go3, wv3, w3, dr3;
    logic       ack4, rej4, turn4, busy4, go4, wv4, w4, dr4;
    logic [8:0]  gm3, ga3;
    logic [15:0] gm4, ga4;
`ifdef GRID_TURN_TIMEOUT_EN
    logic tp3, tp4;
`endif

    always #5 clk = ~clk;

    grid_game_ctrl #(.BOARD_N(3), .TIMEOUT(16)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .move_valid(mv3), .sel_x(x3), .sel_y(y3),
        .move_ack(ack3), .move_rej(rej3), .game_mem(gm3), .grid_active(ga3), .turn(turn3),
        .busy(busy3), .game_over(go3), .winner_valid(wv3), .winner(w3), .draw(dr3)
`ifdef GRID_TURN_TIMEOUT_EN
        , .timeout_pulse(tp3)
`endif
    );

    grid_game_ctrl #(.BOARD_N(4), .TIMEOUT(16)) u4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .move_valid(mv4), .sel_x(x4), .sel_y(y4),
        .move_ack(ack4), .move_rej(rej4), .game_mem(gm4), .grid_active(ga4), .turn(turn4),
        .busy(busy4), .game_over(go4), .winner_valid(wv4), .winner(w4), .draw(dr4)
`ifdef GRID_TURN_TIMEOUT_EN
        , .timeout_pulse(tp4)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    // Reference board: full-board line scan, independent of which cell moved last.
    logic [63:0] m_act, m_mem;
    bit m_turn, m_over, m_wv, m_w, m_dr;

    function automatic bit has_line(int n, logic [63:0] act, logic [63:0] mem, bit p);
        bit ok;
        for (int r = 0; r < n; r++) begin
            ok = 1;
            for (int c = 0; c < n; c++) if (!act[r*n+c] || mem[r*n+c] != p) ok = 0;
            if (ok) return 1;
        end
        for (int c = 0; c < n; c++) begin
            ok = 1;
            for (int r = 0; r < n; r++) if (!act[r*n+c] || mem[r*n+c] != p) ok = 0;
            if (ok) return 1;
        end
        ok = 1;
        for (int k = 0; k < n; k++) if (!act[k*n+k] || mem[k*n+k] != p) ok = 0;
        if (ok) return 1;
        ok = 1;
        for (int k = 0; k < n; k++) if (!act[k*n+n-1-k] || mem[k*n+n-1-k] != p) ok = 0;
        return ok;
    endfunction

    task automatic model_reset();
        m_act = '0; m_mem = '0;
        m_turn = 0; m_over = 0; m_wv = 0; m_w = 0; m_dr = 0;
    endtask

    task automatic sample(input int n, output logic [63:0] act, output logic [63:0] mem,
                          output logic [4:0] fl, output logic a, output logic r, output logic b);
        if (n == 3) begin
            act = {55'd0, ga3}; mem = {55'd0, gm3};
            fl = {turn3, go3, wv3, w3, dr3}; a = ack3; r = rej3; b = busy3;
        end else begin
            act = {48'd0, ga4}; mem = {48'd0, gm4};
            fl = {turn4, go4, wv4, w4, dr4}; a = ack4; r = rej4; b = busy4;
        end
    endtask

    task automatic drive(input int n, input logic v, input int x, input int y);
        if (n == 3) begin mv3 = v; x3 = 2'(x); y3 = 2'(y); end
        else        begin mv4 = v; x4 = 2'(x); y4 = 2'(y); end
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_reset();
    endtask

    task automatic do_move(input int n, input int x, input int y);
        logic [63:0] act, mem, full;
        logic [4:0]  fl;
        logic        a, r, b;
        bit          exp_ack, got, exp;
        int          bc, idx;
        idx = y * n + x;
        exp_ack = !m_over && x < n && y < n && !m_act[idx];
        exp_q.push_back(exp_ack);
        @(negedge clk);
        drive(n, 1'b1, x, y);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            sample(n, act, mem, fl, a, r, b);
            if (a || r) got = 1;
        end
        drive(n, 1'b0, 0, 0);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL resp(%0d,%0d) n=%0d: no ack/rej within 10 cycles, expected ack=%0b", x, y, n, exp);
        end else if (a !== exp || (a && r)) begin
            n_err++;
            $display("FAIL resp(%0d,%0d) n=%0d: ack=%0b rej=%0b, expected ack=%0b", x, y, n, a, r, exp);
        end
        if (got && a) begin
            bc = 0;
            while (b && bc < 10) begin
                bc++;
                @(posedge clk); #1;
                sample(n, act, mem, fl, a, r, b);
            end
            n_cmp++;
            if (bc != 4) begin
                n_err++;
                $display("FAIL busy_len(%0d,%0d): %0d cycles, expected 4", x, y, bc);
            end
        end
        if (exp_ack) begin
            m_act[idx] = 1'b1;
            m_mem[idx] = m_turn;
            full = (64'd1 << (n * n)) - 64'd1;
            if (has_line(n, m_act, m_mem, m_turn)) begin
                m_over = 1; m_wv = 1; m_w = m_turn;
            end else if ((m_act & full) == full) begin
                m_over = 1; m_dr = 1;
            end else begin
                m_turn = ~m_turn;
            end
        end
        sample(n, act, mem, fl, a, r, b);
        n_cmp++;
        if (act !== m_act || mem !== m_mem) begin
            n_err++;
            $display("FAIL board(%0d,%0d): act=%h mem=%h, expected act=%h mem=%h", x, y, act, mem, m_act, m_mem);
        end
        n_cmp++;
        if (fl !== {m_turn, m_over, m_wv, m_w, m_dr}) begin
            n_err++;
            $display("FAIL flags(%0d,%0d) {turn,over,wv,w,draw}: %b, expected %b", x, y, fl,
                     {m_turn, m_over, m_wv, m_w, m_dr});
        end
        @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        n_cmp++;
        if ({ack3, rej3, gm3, ga3, turn3, busy3, go3, wv3, w3, dr3} !== '0 ||
            {ack4, rej4, gm4, ga4, turn4, busy4, go4, wv4, w4, dr4} !== '0) begin
            n_err++;
            $display("FAIL %s: u3 ga=%h gm=%h turn=%b busy=%b over=%b / u4 ga=%h gm=%h turn=%b, expected all 0",
                     tag, ga3, gm3, turn3, busy3, go3, ga4, gm4, turn4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_idle_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        check_idle_zero("idle_after_reset");
        model_reset();
    endtask

    task automatic test_row_win();
        do_clear();
        do_move(3, 0, 0); do_move(3, 0, 1); do_move(3, 1, 0);
        do_move(3, 1, 1); do_move(3, 2, 0);
        n_cmp++;
        if (wv3 !== 1'b1 || w3 !== 1'b0 || gm3[2:0] !== 3'b000 || ga3[2:0] !== 3'b111) begin
            n_err++;
            $display("FAIL row_win: wv=%b w=%b gm[2:0]=%b ga[2:0]=%b, expected 1 0 000 111", wv3, w3, gm3[2:0], ga3[2:0]);
        end
    endtask

    task automatic test_reject();
        do_clear();
        do_move(3, 1, 1);
        do_move(3, 1, 1);
        do_move(3, 3, 0);
        do_move(3, 0, 3);
    endtask

    task automatic test_draw();
        do_clear();
        do_move(3, 0, 0); do_move(3, 1, 0); do_move(3, 2, 0);
        do_move(3, 1, 1); do_move(3, 1, 2); do_move(3, 0, 2);
        do_move(3, 0, 1); do_move(3, 2, 1); do_move(3, 2, 2);
        n_cmp++;
        if (dr3 !== 1'b1 || wv3 !== 1'b0 || ga3 !== 9'h1FF || go3 !== 1'b1) begin
            n_err++;
            $display("FAIL draw: draw=%b wv=%b ga=%h over=%b, expected 1 0 1ff 1", dr3, wv3, ga3, go3);
        end
        do_move(3, 0, 0);
        do_clear();
        check_idle_zero("clear_after_draw");
    endtask

    task automatic test_anti_diag4();
        do_clear();
        do_move(4, 0, 0); do_move(4, 3, 0); do_move(4, 1, 0); do_move(4, 2, 1);
        do_move(4, 2, 0); do_move(4, 1, 2); do_move(4, 0, 1); do_move(4, 0, 3);
        n_cmp++;
        if (wv4 !== 1'b1 || w4 !== 1'b1) begin
            n_err++;
            $display("FAIL anti_diag4: wv=%b w=%b, expected 1 1", wv4, w4);
        end
    endtask

    task automatic test_clear_priority();
        do_clear();
        @(negedge clk);
        drive(3, 1'b1, 0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        drive(3, 1'b0, 0, 0);
        clear = 1'b0;
        n_cmp++;
        if (ack3 !== 1'b0 || rej3 !== 1'b0 || ga3 !== 9'h000) begin
            n_err++;
            $display("FAIL clear_priority: ack=%b rej=%b ga=%h, expected 0 0 000", ack3, rej3, ga3);
        end
    endtask

    task automatic test_reset_mid_check();
        bit got;
        do_clear();
        @(negedge clk);
        drive(3, 1'b1, 1, 1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (ack3) got = 1;
        end
        drive(3, 1'b0, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (!got || busy3 !== 1'b0 || ga3 !== 9'h000 || turn3 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_check: acked=%0b busy=%b ga=%h turn=%b, expected 1 0 000 0", got, busy3, ga3, turn3);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

`ifdef GRID_TURN_TIMEOUT_EN
    task automatic test_timeout();
        int first, cnt;
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        first = 0; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (tp3) begin
                cnt++;
                if (first == 0) first = i;
            end
            if (i == 16) begin
                n_cmp++;
                if (turn3 !== 1'b1) begin
                    n_err++;
                    $display("FAIL timeout_turn: turn=%b, expected 1", turn3);
                end
            end
        end
        n_cmp++;
        if (first != 16 || cnt != 1) begin
            n_err++;
            $display("FAIL timeout_pulse: first at cycle %0d count %0d, expected 16 and 1", first, cnt);
        end
        model_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_row_win();
        test_reject();
        test_draw();
        test_anti_diag4();
        test_clear_priority();
        test_reset_mid_check();
`ifdef GRID_TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
